// File: rtl/tls_pkg.sv
// Shared definitions for the intersection controller: phase codes, default
// counter width and the per-road lamp decode.
package tls_pkg;

    localparam int CW_DEF = 4;

    // Phase codes, also exported on the phase status output.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NS_G = 3'd1,
        NS_Y = 3'd2,
        AR1  = 3'd3,
        EW_G = 3'd4,
        EW_Y = 3'd5,
        AR2  = 3'd6,
        EMRG = 3'd7
    } state_t;

    // One road's lamp head.
    typedef struct packed {
        logic g;
        logic y;
        logic r;
    } lamp_t;

    localparam lamp_t LAMP_GREEN  = '{g: 1'b1, y: 1'b0, r: 1'b0};
    localparam lamp_t LAMP_YELLOW = '{g: 1'b0, y: 1'b1, r: 1'b0};
    localparam lamp_t LAMP_RED    = '{g: 1'b0, y: 1'b0, r: 1'b1};

    // A road is red everywhere except its own green and yellow phases, so the
    // two roads can never be non-red together.
    function automatic lamp_t ns_lamp_of(input state_t s);
        case (s)
            NS_G:    return LAMP_GREEN;
            NS_Y:    return LAMP_YELLOW;
            default: return LAMP_RED;
        endcase
    endfunction

    function automatic lamp_t ew_lamp_of(input state_t s);
        case (s)
            EW_G:    return LAMP_GREEN;
            EW_Y:    return LAMP_YELLOW;
            default: return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/intersection_ctrl_if.sv
// Bundle of configuration, request and lamp/walk signals between the
// intersection controller (slave) and whatever drives and observes it (master).
interface intersection_ctrl_if
    import tls_pkg::*;
#(
    parameter int CW = CW_DEF
);
    logic          set;
    logic [CW-1:0] g_in;
    logic [CW-1:0] y_in;
    logic [CW-1:0] ar_in;
    logic          ped_req_ns;
    logic          ped_req_ew;
    logic          emerg;
    logic          ns_g;
    logic          ns_y;
    logic          ns_r;
    logic          ew_g;
    logic          ew_y;
    logic          ew_r;
    logic          walk_ns;
    logic          walk_ew;
    logic [2:0]    phase;

    modport master (
        output set, g_in, y_in, ar_in, ped_req_ns, ped_req_ew, emerg,
        input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk_ns, walk_ew, phase
    );

    modport slave (
        input  set, g_in, y_in, ar_in, ped_req_ns, ped_req_ew, emerg,
        output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk_ns, walk_ew, phase
    );
endinterface

// File: rtl/intersection_ctrl_phase_timer.sv
// Phase timer shared by every phase: count starts at 1 on phase entry and
// increments once per cycle; done flags the last cycle of the phase.
module phase_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic          advance,
    input  logic [CW-1:0] dur,
    output logic [CW-1:0] count,
    output logic          done
);

    // Count register: restart wins over advance; held while not advancing.
    // NOTE: asynchronous reset sits in the sensitivity list so it acts without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CW'(1);
        end else if (restart) begin
            count <= CW'(1);
        end else if (advance) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == dur);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection sequencer: programmable green/yellow/all-red phases,
// pedestrian walk service with green truncation, and emergency all-red.
module intersection_ctrl
    import tls_pkg::*;
#(
    parameter int CW    = CW_DEF,
    parameter int MIN_G = 2
) (
    input  logic               clk,
    input  logic               reset,
    intersection_ctrl_if.slave bus
);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] g_dur;
    logic [CW-1:0] y_dur;
    logic [CW-1:0] ar_dur;
    logic [CW-1:0] dur_sel;
    logic [CW-1:0] count;
    logic          done;
    logic          restart;
    logic          advance;
    logic          at_min;
    logic          pend_ns;
    logic          pend_ew;
    logic          walk_ns_q;
    logic          walk_ew_q;
    logic          enter_ns_g;
    logic          enter_ew_g;
    lamp_t         ns_lamp;
    lamp_t         ew_lamp;

    // A programmed duration of zero behaves as a single cycle.
    function automatic logic [CW-1:0] min1(input logic [CW-1:0] d);
        return (d == '0) ? CW'(1) : d;
    endfunction

    assign at_min = (count >= CW'(MIN_G));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: set beats emerg, emerg beats normal sequencing, IDLE only leaves on set.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        if (bus.set) begin
            state_next = NS_G;
        end else if (bus.emerg && state != IDLE) begin
            state_next = EMRG;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                NS_G: if (done || (pend_ew && at_min)) state_next = NS_Y;
                NS_Y: if (done) state_next = AR1;
                AR1:  if (done) state_next = EW_G;
                EW_G: if (done || (pend_ns && at_min)) state_next = EW_Y;
                EW_Y: if (done) state_next = AR2;
                AR2:  if (done) state_next = NS_G;
                EMRG: state_next = AR1;
                default: state_next = IDLE;
            endcase
        end
    end

    // Duration for the phase currently running.
    always_comb begin
        dur_sel = g_dur;
        case (state)
            NS_G, EW_G: dur_sel = g_dur;
            NS_Y, EW_Y: dur_sel = y_dur;
            AR1, AR2:   dur_sel = ar_dur;
            default:    dur_sel = g_dur;
        endcase
    end

    // Any phase change or set starts the timer over; EMRG pins it at 1 until exit.
    assign restart = bus.set || (state_next != state) || (state == EMRG);
    assign advance = (state != IDLE);

    phase_timer #(.CW(CW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .advance (advance),
        .dur     (dur_sel),
        .count   (count),
        .done    (done)
    );

    // Duration registers, latched on set with zero promoted to one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_dur  <= CW'(1);
            y_dur  <= CW'(1);
            ar_dur <= CW'(1);
        end else if (bus.set) begin
            g_dur  <= min1(bus.g_in);
            y_dur  <= min1(bus.y_in);
            ar_dur <= min1(bus.ar_in);
        end
    end

    // Green entry through normal sequencing (entry by set never carries a walk).
    assign enter_ns_g = (state_next == NS_G) && (state != NS_G);
    assign enter_ew_g = (state_next == EW_G) && (state != EW_G);

    // Pedestrian pending flags and walk flops: a pending request is consumed on
    // entry to its road's green and lights walk for that whole green.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_ns   <= 1'b0;
            pend_ew   <= 1'b0;
            walk_ns_q <= 1'b0;
            walk_ew_q <= 1'b0;
        end else if (bus.set) begin
            pend_ns   <= 1'b0;
            pend_ew   <= 1'b0;
            walk_ns_q <= 1'b0;
            walk_ew_q <= 1'b0;
        end else begin
            pend_ns   <= enter_ns_g ? bus.ped_req_ns : (pend_ns | bus.ped_req_ns);
            pend_ew   <= enter_ew_g ? bus.ped_req_ew : (pend_ew | bus.ped_req_ew);
            walk_ns_q <= (state_next == NS_G) ? (enter_ns_g ? pend_ns : walk_ns_q) : 1'b0;
            walk_ew_q <= (state_next == EW_G) ? (enter_ew_g ? pend_ew : walk_ew_q) : 1'b0;
        end
    end

    // Moore output decode from registered state only.
    assign ns_lamp     = ns_lamp_of(state);
    assign ew_lamp     = ew_lamp_of(state);
    assign bus.ns_g    = ns_lamp.g;
    assign bus.ns_y    = ns_lamp.y;
    assign bus.ns_r    = ns_lamp.r;
    assign bus.ew_g    = ew_lamp.g;
    assign bus.ew_y    = ew_lamp.y;
    assign bus.ew_r    = ew_lamp.r;
    assign bus.walk_ns = walk_ns_q;
    assign bus.walk_ew = walk_ew_q;
    assign bus.phase   = state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Self-checking bench for intersection_ctrl: each scenario pushes the expected
// per-cycle phase/lamp/walk picture into a scoreboard queue that a negedge
// consumer pops and compares; safety properties are checked every cycle.
module tb_intersection_ctrl;

    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_NSG  = 3'd1;
    localparam logic [2:0] P_NSY  = 3'd2;
    localparam logic [2:0] P_AR1  = 3'd3;
    localparam logic [2:0] P_EWG  = 3'd4;
    localparam logic [2:0] P_EWY  = 3'd5;
    localparam logic [2:0] P_AR2  = 3'd6;
    localparam logic [2:0] P_EMRG = 3'd7;

    localparam logic [5:0] ALL_RED = 6'b001_001;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    intersection_ctrl_if #(.CW(4)) bus();

    intersection_ctrl #(.CW(4), .MIN_G(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0] phase;
        logic [5:0] lamps;
        logic [1:0] walk;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [5:0] lamps;
    logic [1:0] walk;
    assign lamps = {bus.ns_g, bus.ns_y, bus.ns_r, bus.ew_g, bus.ew_y, bus.ew_r};
    assign walk  = {bus.walk_ns, bus.walk_ew};

    // Expected picture for one cycle, from the lamp table (NS g/y/r, EW g/y/r).
    function automatic exp_t mk(input logic [2:0] ph, input logic wns, input logic wew,
                                input string tag);
        exp_t e;
        e.phase = ph;
        e.walk  = {wns, wew};
        e.tag   = tag;
        case (ph)
            P_NSG:   e.lamps = 6'b100_001;
            P_NSY:   e.lamps = 6'b010_001;
            P_EWG:   e.lamps = 6'b001_100;
            P_EWY:   e.lamps = 6'b001_010;
            default: e.lamps = ALL_RED;
        endcase
        return e;
    endfunction

    task automatic push(input logic [2:0] ph, input int n, input logic wns, input logic wew,
                        input string tag);
        repeat (n) sb.push_back(mk(ph, wns, wew, tag));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the scoreboard to empty, bounded; ends at the first uncovered cycle.
    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d expectations left, required 0", tag, sb.size());
            sb.delete();
        end
    endtask

    // Load durations with a one-cycle set pulse; returns in the first NS_G cycle.
    task automatic config_set(input logic [3:0] g, input logic [3:0] y, input logic [3:0] ar);
        bus.g_in  = g;
        bus.y_in  = y;
        bus.ar_in = ar;
        bus.set   = 1'b1;
        tick();
        bus.set   = 1'b0;
    endtask

    // Scoreboard consumer: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({bus.phase, lamps, walk} !== {e.phase, e.lamps, e.walk}) begin
                errors++;
                $display("FAIL %s: got phase=%0d lamps=%b walk=%b, required phase=%0d lamps=%b walk=%b",
                         e.tag, bus.phase, lamps, walk, e.phase, e.lamps, e.walk);
            end
        end
    end

    // Safety: never both roads non-red; walk only alongside its own green.
    always @(negedge clk) begin
        checks++;
        if ((!bus.ns_r && !bus.ew_r) || (bus.walk_ns && !bus.ns_g) || (bus.walk_ew && !bus.ew_g)) begin
            errors++;
            $display("FAIL safety: got lamps=%b walk=%b, required a red road and walk only on green",
                     lamps, walk);
        end
    end

    task automatic test_reset();
        reset          = 1'b1;
        bus.set        = 1'b0;
        bus.g_in       = '0;
        bus.y_in       = '0;
        bus.ar_in      = '0;
        bus.ped_req_ns = 1'b0;
        bus.ped_req_ew = 1'b0;
        bus.emerg      = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({bus.phase, lamps, walk} !== {P_IDLE, ALL_RED, 2'b00}) begin
                errors++;
                $display("FAIL idle_hold: got phase=%0d lamps=%b walk=%b, required phase=0 lamps=%b walk=00",
                         bus.phase, lamps, walk, ALL_RED);
            end
        end
    endtask

    task automatic test_cycle();
        config_set(4'd3, 4'd2, 4'd1);
        repeat (2) begin
            push(P_NSG, 3, 0, 0, "cycle_ns_g");
            push(P_NSY, 2, 0, 0, "cycle_ns_y");
            push(P_AR1, 1, 0, 0, "cycle_ar1");
            push(P_EWG, 3, 0, 0, "cycle_ew_g");
            push(P_EWY, 2, 0, 0, "cycle_ew_y");
            push(P_AR2, 1, 0, 0, "cycle_ar2");
        end
        wait_drain(40, "cycle");
    endtask

    task automatic test_ped();
        config_set(4'd6, 4'd2, 4'd1);
        push(P_NSG, 2, 0, 0, "ped_ns_g_trunc");
        push(P_NSY, 2, 0, 0, "ped_ns_y");
        push(P_AR1, 1, 0, 0, "ped_ar1");
        push(P_EWG, 4, 0, 1, "ped_ew_g_walk_trunc");
        push(P_EWY, 2, 0, 0, "ped_ew_y");
        push(P_AR2, 1, 0, 0, "ped_ar2");
        push(P_NSG, 6, 1, 0, "ped_ns_g_walk");
        push(P_NSY, 2, 0, 0, "ped_ns_y2");
        bus.ped_req_ew = 1'b1;          // during NS_G count=1
        tick();
        bus.ped_req_ew = 1'b0;
        repeat (6) tick();              // EW_G count=3
        bus.ped_req_ns = 1'b1;
        tick();
        bus.ped_req_ns = 1'b0;
        wait_drain(40, "ped");
    endtask

    task automatic test_emerg();
        config_set(4'd3, 4'd2, 4'd2);
        push(P_NSG,  3, 0, 0, "emg_ns_g");
        push(P_NSY,  2, 0, 0, "emg_ns_y");
        push(P_AR1,  2, 0, 0, "emg_ar1");
        push(P_EWG,  2, 0, 0, "emg_ew_g_pre");
        push(P_EMRG, 4, 0, 0, "emg_all_red");
        push(P_AR1,  2, 0, 0, "emg_clear_ar1");
        push(P_EWG,  3, 0, 0, "emg_ew_g_restart");
        push(P_EWY,  2, 0, 0, "emg_ew_y");
        push(P_AR2,  2, 0, 0, "emg_ar2");
        push(P_NSG,  3, 0, 0, "emg_ns_g2");
        repeat (8) tick();              // EW_G count=2
        bus.emerg = 1'b1;
        repeat (4) tick();
        bus.emerg = 1'b0;
        wait_drain(40, "emerg");
    endtask

    task automatic test_set_emerg();
        config_set(4'd3, 4'd2, 4'd1);
        repeat (4) tick();              // inside NS_Y
        bus.g_in  = 4'd0;
        bus.y_in  = 4'd2;
        bus.ar_in = 4'd1;
        bus.set   = 1'b1;
        bus.emerg = 1'b1;
        tick();
        bus.set   = 1'b0;
        bus.emerg = 1'b0;
        push(P_NSG, 1, 0, 0, "setemg_ns_g");
        push(P_NSY, 2, 0, 0, "setemg_ns_y");
        push(P_AR1, 1, 0, 0, "setemg_ar1");
        push(P_EWG, 1, 0, 0, "setemg_ew_g");
        push(P_EWY, 2, 0, 0, "setemg_ew_y");
        push(P_AR2, 1, 0, 0, "setemg_ar2");
        push(P_NSG, 1, 0, 0, "setemg_ns_g2");
        wait_drain(20, "setemg");
    endtask

    task automatic test_async_reset();
        config_set(4'd3, 4'd3, 4'd1);
        repeat (4) tick();              // NS_Y count=2
        checks++;
        if (bus.phase !== P_NSY) begin
            errors++;
            $display("FAIL pre_reset_phase: got %0d, required %0d", bus.phase, P_NSY);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.phase, lamps, walk} !== {P_IDLE, ALL_RED, 2'b00}) begin
            errors++;
            $display("FAIL async_reset: got phase=%0d lamps=%b walk=%b, required phase=0 lamps=%b walk=00",
                     bus.phase, lamps, walk, ALL_RED);
        end
        tick();
        reset          = 1'b0;
        bus.emerg      = 1'b1;          // no effect in IDLE
        bus.ped_req_ns = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({bus.phase, lamps} !== {P_IDLE, ALL_RED}) begin
                errors++;
                $display("FAIL idle_after_reset: got phase=%0d lamps=%b, required phase=0 lamps=%b",
                         bus.phase, lamps, ALL_RED);
            end
        end
        bus.emerg      = 1'b0;
        bus.ped_req_ns = 1'b0;
        config_set(4'd2, 4'd1, 4'd1);
        push(P_NSG, 2, 0, 0, "post_reset_ns_g");
        push(P_NSY, 1, 0, 0, "post_reset_ns_y");
        push(P_AR1, 1, 0, 0, "post_reset_ar1");
        push(P_EWG, 2, 0, 0, "post_reset_ew_g");
        wait_drain(20, "post_reset");
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_ped();
        test_emerg();
        test_set_emerg();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
